// File: rtl/icache.sv
// Direct-mapped, single-word-per-frame instruction cache with a blocking
// two-state fill engine and saturating hit/miss statistics.
module icache #(
    parameter int unsigned NSETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        flush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    localparam int unsigned IDX_W = $clog2(NSETS);
    localparam int unsigned TAG_W = 30 - IDX_W;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FETCH = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [31:0]      miss_addr_q;
    logic [NSETS-1:0] valid_q;
    logic [15:0]      hit_count_q, miss_count_q;

    logic [TAG_W-1:0] tag_mem  [NSETS];
    logic [31:0]      data_mem [NSETS];

    logic [IDX_W-1:0] req_index, miss_index;
    logic [TAG_W-1:0] req_tag, miss_tag;
    logic             hit;
    logic             fill;
    logic             start_miss;

    // Byte-offset bits of the request carry no information for word fetches.
    logic unused_addr_bits;
    assign unused_addr_bits = ^imemaddr[1:0];

    assign req_index  = imemaddr[IDX_W+1:2];
    assign req_tag    = imemaddr[31:IDX_W+2];
    assign miss_index = miss_addr_q[IDX_W+1:2];
    assign miss_tag   = miss_addr_q[31:IDX_W+2];

    assign hit = imemREN && (state_q == IDLE) && valid_q[req_index]
                 && (tag_mem[req_index] == req_tag);

    // Flush takes priority over a fill completing on the same edge.
    assign fill       = (state_q == FETCH) && !iwait && !flush;
    assign start_miss = (state_q == IDLE) && imemREN && !hit && !flush;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_miss) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (flush || !iwait) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            miss_addr_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (start_miss) begin
                miss_addr_q <= imemaddr;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (fill) begin
            valid_q[miss_index] <= 1'b1;
        end
    end

    // Tag and data arrays need no reset; valid bits gate every use.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_mem[miss_index]  <= miss_tag;
            data_mem[miss_index] <= iload;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_count_q  <= 16'd0;
            miss_count_q <= 16'd0;
        end else begin
            if (hit && (hit_count_q != 16'hFFFF)) begin
                hit_count_q <= hit_count_q + 16'd1;
            end
            if (start_miss && (miss_count_q != 16'hFFFF)) begin
                miss_count_q <= miss_count_q + 16'd1;
            end
        end
    end

    assign ihit       = hit;
    assign imemload   = hit ? data_mem[req_index] : 32'd0;
    assign iREN       = (state_q == FETCH);
    assign iaddr      = (state_q == FETCH) ? miss_addr_q : 32'd0;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter NSETS, default 16, number of direct-mapped frames (power of two, 2..64).
REQ-002 Port CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 Port RST  in  1  reset, asynchronous, active-high; one clock; reset is asynchronous and active-high.
REQ-004 Port imemREN  in  1  datapath instruction read request.
REQ-005 Port imemaddr  in  32  datapath instruction word address (bits 1:0 ignored).
REQ-006 Port ihit  out  1  requested word valid on imemload this cycle.
REQ-007 Port imemload  out  32  instruction word returned to datapath.
REQ-008 Port flush  in  1  invalidate all frames.
REQ-009 Port iREN  out  1  memory-side read request.
REQ-010 Port iaddr  out  32  memory-side word address.
REQ-011 Port iwait  in  1  memory busy; low means iload valid this cycle.
REQ-012 Port iload  in  32  memory-side read data.
REQ-013 Port hit_count  out  16  saturating count of hits.
REQ-014 Port miss_count  out  16  saturating count of misses (fills started).

Function
REQ-015 Frame fields: valid 1 bit, tag = imemaddr[31:2+log2(NSETS)], data 32 bits; index = imemaddr[1+log2(NSETS):2].
REQ-016 Hit (combinational): ihit = imemREN & state IDLE & valid[index] & tag match; imemload = data[index] when ihit, else 0.
REQ-017 FSM states IDLE, FETCH only.
REQ-018 IDLE -> FETCH on imemREN & !hit & !flush; latch imemaddr into miss_addr on that edge; miss_count +1.
REQ-019 In FETCH: iREN = 1, iaddr = miss_addr; in IDLE: iREN = 0, iaddr = 0.
REQ-020 FETCH with iwait = 1: hold state, no frame write.
REQ-021 FETCH with iwait = 0: write frame[miss_addr index] = {valid 1, miss_addr tag, iload}; -> IDLE.
REQ-022 Miss latency: hit asserted earliest on the cycle after the fill edge (min 2 cycles from miss detection with iwait = 0).
REQ-023 Changes of imemREN/imemaddr during FETCH do not affect the fill in progress; fill completes to miss_addr.
REQ-024 ihit never asserted in FETCH, even if current imemaddr would match another frame.
REQ-025 flush in IDLE: clear all valid bits next edge; no FETCH entry that cycle; ihit still evaluates on pre-flush contents that cycle.
REQ-026 flush in FETCH: clear all valid, abort to IDLE, iREN low next cycle; flush wins over simultaneous fill completion (frame not written).
REQ-027 hit_count +1 on each edge where ihit = 1; both counters saturate at 16'hFFFF, never wrap.
REQ-028 Fill of an index whose frame is valid with a different tag overwrites it (no replacement choice).

Reset
REQ-029 RST asserted: all valid = 0, state = IDLE, miss_addr = 0, hit_count = 0, miss_count = 0, immediately without clock.
REQ-030 Outputs during/after reset: ihit 0, imemload 0, iREN 0, iaddr 0.
REQ-031 RST mid-FETCH: fill aborted, frame not written, iREN drops asynchronously.
REQ-032 Frame data contents need not be reset.

Verification
REQ-033 Cold miss: RST, imemREN=1, imemaddr=0x00000040, memory iwait=1 for 3 cycles then iload=0x3C010001 -> iREN/iaddr=0x40 for 4 cycles, ihit=1 imemload=0x3C010001 next cycle, miss_count=1, hit_count increments thereafter.
REQ-034 Conflict: fill 0x00000004 then 0x00000044 (same index, NSETS=16) -> second misses, overwrites; re-read 0x04 misses again, miss_count=3.
REQ-035 Address change mid-fill: miss on 0x100, switch imemaddr to 0x200 during FETCH -> iaddr stays 0x100, frame for 0x100 filled, then 0x200 misses.
REQ-036 Flush race: in FETCH drive flush=1 same cycle iwait=0 -> no frame written, state IDLE, re-request of same address misses.
REQ-037 Reset mid-fill: assert RST between edges in FETCH -> iREN=0 immediately, counters 0, prior valid frames miss afterwards.
REQ-038 Saturation: force 65 540 consecutive hits on 0x00000008 -> hit_count holds 16'hFFFF.
